// File: rtl/pll_spi_cfg.sv
// Runtime-reconfigurable serial programmer for ADF4158/ADF4159-class PLLs: shadow register file,
// dirty-register flush (MSB first, highest index first) with LE framing. Optional PLL_LOCK_WAIT_EN.
module pll_spi_cfg #(
  parameter int unsigned NUM_REGS     = 10,
  parameter int unsigned REG_W        = 32,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned LE_HOLD      = 2,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [REG_W-1:0]            wr_data,
  input  logic                        start,
  input  logic                        start_all,
  output logic                        busy,
  output logic                        done,
  output logic                        lock_err,
  output logic                        ce,
  output logic                        le,
  output logic                        sclk,
  output logic                        sdata,
  input  logic                        muxout,
  output logic                        lock
);

  localparam int unsigned ADDR_W  = $clog2(NUM_REGS);
  localparam int unsigned PH_MAX  = 2 * CLK_DIV - 1;
  localparam int unsigned PH_W    = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;
  localparam int unsigned BIT_W   = (REG_W > 1) ? $clog2(REG_W) : 1;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > LE_HOLD) ? LOCK_TIMEOUT : LE_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef PLL_LOCK_WAIT_EN
  localparam logic [2:0] S_WAIT_LOCK = 3'd6;
`endif

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] cur_idx, cur_d;
  logic              scan_all, scan_all_d;
  logic [PH_W-1:0]   ph, ph_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [REG_W-1:0]  shreg, shreg_d;
  logic              busy_d, done_d, le_d, sclk_d, sdata_d;
  logic              set_all, clr_dirty;
  logic              found, more, wr_ok;
  logic [ADDR_W-1:0] sel;
  logic              sync1;
  logic [NUM_REGS-1:0] dirty;
  logic [REG_W-1:0]  shadow [NUM_REGS];
`ifdef PLL_LOCK_WAIT_EN
  logic              lock_err_d;
`endif

  assign wr_ok = wr_en && (32'(wr_addr) < NUM_REGS);

  // Next-state, counters and next registered pin values
  always_comb begin
    state_d    = state;
    cur_d      = cur_idx;
    scan_all_d = scan_all;
    ph_d       = ph;
    bit_d      = bit_cnt;
    cnt_d      = cnt;
    shreg_d    = shreg;
    set_all    = 1'b0;
    clr_dirty  = 1'b0;
    found      = 1'b0;
    sel        = '0;
`ifdef PLL_LOCK_WAIT_EN
    lock_err_d = lock_err;
`endif
    // Highest dirty index below the last one sent (or any, on the first scan)
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (dirty[i] && (scan_all || (ADDR_W'(i) < cur_idx))) begin
        found = 1'b1;
        sel   = ADDR_W'(i);
      end
    end
    // Lookahead so the last word goes straight to completion; includes a same-cycle write
    more = found || (wr_ok && (wr_addr < cur_idx));

    case (state)
      S_IDLE: begin
        if (ce && (start || start_all)) begin
          state_d    = S_SCAN;
          scan_all_d = 1'b1;
          set_all    = start_all;
`ifdef PLL_LOCK_WAIT_EN
          lock_err_d = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        scan_all_d = 1'b0;
        if (found) begin
          cur_d   = sel;
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_LOAD: begin
        shreg_d   = shadow[cur_idx];
        clr_dirty = 1'b1;
        ph_d      = '0;
        bit_d     = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (ph == PH_W'(PH_MAX)) begin
          ph_d = '0;
          if (bit_cnt == BIT_W'(REG_W - 1)) begin
            cnt_d   = '0;
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_cnt + 1'b1;
            shreg_d = {shreg[REG_W-2:0], 1'b0};
          end
        end else begin
          ph_d = ph + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt == CNT_W'(LE_HOLD - 1)) begin
          if (more) begin
            state_d = S_SCAN;
          end else begin
`ifdef PLL_LOCK_WAIT_EN
            cnt_d   = '0;
            state_d = S_WAIT_LOCK;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef PLL_LOCK_WAIT_EN
      S_WAIT_LOCK: begin
        if (lock) begin
          lock_err_d = 1'b0;
          state_d    = S_DONE;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          lock_err_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    le_d    = (state_d != S_SHIFT);
    sclk_d  = (state_d == S_SHIFT) && (ph_d >= PH_W'(CLK_DIV));
    sdata_d = (state_d == S_SHIFT) && shreg_d[REG_W-1];
  end

  // FSM state and registered device pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_idx  <= '0;
      scan_all <= 1'b0;
      ph       <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ce       <= 1'b0;
      le       <= 1'b1;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
    end else begin
      state    <= state_d;
      cur_idx  <= cur_d;
      scan_all <= scan_all_d;
      ph       <= ph_d;
      bit_cnt  <= bit_d;
      cnt      <= cnt_d;
      shreg    <= shreg_d;
      busy     <= busy_d;
      done     <= done_d;
      ce       <= 1'b1;
      le       <= le_d;
      sclk     <= sclk_d;
      sdata    <= sdata_d;
    end
  end

  // Shadow file; a host write re-marks dirty even in the cycle the word is snapshotted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      dirty <= '1;
    end else begin
      if (set_all) dirty <= '1;
      if (clr_dirty) dirty[cur_idx] <= 1'b0;
      if (wr_ok) begin
        shadow[wr_addr] <= wr_data;
        dirty[wr_addr]  <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous MUXOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lock  <= 1'b0;
    end else begin
      sync1 <= muxout;
      lock  <= sync1;
    end
  end

`ifdef PLL_LOCK_WAIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_err <= 1'b0;
    else        lock_err <= lock_err_d;
  end
`else
  assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_pll_spi_cfg.sv
// Directed self-checking bench for pll_spi_cfg: captures serial words on sclk rise, frames on le rise.
module tb_pll_spi_cfg;

`ifdef PLL_LOCK_WAIT_EN
  localparam int LW = 1;
`else
  localparam int LW = 0;
`endif
  localparam int WORD_CYC = 132;

  logic        clk, rst_n, wr_en, start, start_all, muxout;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, lock_err, ce, le, sclk, sdata, lock;

  pll_spi_cfg dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_all(start_all), .busy(busy), .done(done), .lock_err(lock_err),
    .ce(ce), .le(le), .sclk(sclk), .sdata(sdata), .muxout(muxout), .lock(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] words[$];
  logic [31:0] cap = '0;
  int nbits = 0;
  int sclk_rises = 0;
  int le_falls = 0;
  int done_cnt = 0;

  always @(posedge sclk) begin
    cap = {cap[30:0], sdata};
    nbits++;
    sclk_rises++;
  end
  always @(posedge le) begin
    if (nbits == 32) words.push_back(cap);
    nbits = 0;
  end
  always @(negedge le) le_falls++;
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input logic s, input logic sa);
    @(negedge clk); start = s; start_all = sa;
    @(negedge clk); start = 1'b0; start_all = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk); wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  // Called at the negedge following the start pulse; stops at the negedge where done is seen
  task automatic run_flush(output int busy_n, output int wait_n, output int lo_n,
                           output int hi_after, output bit ok);
    bit seen;
    busy_n = 0; wait_n = 0; lo_n = 0; hi_after = 0; seen = 1'b0;
    while (done !== 1'b1 && wait_n < 20000) begin
      if (busy === 1'b1) busy_n++;
      if (le === 1'b0) begin lo_n++; seen = 1'b1; end
      else if (seen) hi_after++;
      @(negedge clk);
      wait_n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if ({ce, le, sclk, sdata, busy, done, lock_err, lock} !== 8'b0100_0000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 01000000", {ce, le, sclk, sdata, busy, done, lock_err, lock}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ce !== 1'b1) begin n_fail++; $display("FAIL ce_after_release: got %b expected 1", ce); end
  endtask

  task automatic test_full_flush();
    logic [31:0] vals [10];
    int bn, wn, lo, hi, d0; bit ok;
    for (int i = 0; i < 10; i++) begin
      vals[i] = 32'h1357_9BDF ^ (32'h0101_0101 * 32'(i + 1));
      wr(i, vals[i]);
    end
    words.delete();
    d0 = done_cnt;
    pulse(1'b0, 1'b1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_rise: got %b expected 1", busy); end
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL full_done_timeout: got no done expected done"); end
    n_chk++; if (bn !== 1320 + LW) begin n_fail++; $display("FAIL full_busy_len: got %0d expected %0d", bn, 1320 + LW); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_falls: got %b expected 0", busy); end
    n_chk++; if (words.size() !== 10) begin n_fail++; $display("FAIL full_word_count: got %0d expected 10", words.size()); end
    for (int k = 0; k < 10; k++) begin
      if (k < words.size()) begin
        n_chk++; if (words[k] !== vals[9-k]) begin n_fail++; $display("FAIL full_word%0d: got %h expected %h", k, words[k], vals[9-k]); end
      end
    end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_single: got %b expected 0", done); end
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_single_word();
    int bn, wn, lo, hi, r0; bit ok;
    wr(3, 32'h0000_0043);
    words.delete();
    r0 = sclk_rises;
    pulse(1'b1, 1'b0);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (wn !== WORD_CYC + LW) begin n_fail++; $display("FAIL single_done_latency: got %0d expected %0d", wn, WORD_CYC + LW); end
    n_chk++; if (lo !== 128) begin n_fail++; $display("FAIL single_le_low: got %0d expected 128", lo); end
    n_chk++; if (hi !== 2 + LW) begin n_fail++; $display("FAIL single_le_high: got %0d expected %0d", hi, 2 + LW); end
    n_chk++; if (sclk_rises - r0 !== 32) begin n_fail++; $display("FAIL single_sclk_count: got %0d expected 32", sclk_rises - r0); end
    n_chk++; if (words.size() !== 1) begin n_fail++; $display("FAIL single_word_count: got %0d expected 1", words.size()); end
    if (words.size() > 0) begin
      n_chk++; if (words[0] !== 32'h0000_0043) begin n_fail++; $display("FAIL single_word: got %h expected 00000043", words[0]); end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_flush_write();
    logic [31:0] exp3 [3];
    int bn, wn, lo, hi; bit ok;
    exp3[0] = 32'h7777_0007; exp3[1] = 32'h5555_0005; exp3[2] = 32'h1111_1111;
    wr(7, 32'h7777_0007);
    wr(5, 32'h5555_0005);
    wr(1, 32'h0000_0001);
    words.delete();
    pulse(1'b1, 1'b0);
    repeat (170) @(negedge clk);
    wr(5, 32'hA5A5_A5A5);
    wr(1, 32'h1111_1111);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL mid_done_timeout: got no done expected done"); end
    n_chk++; if (words.size() !== 3) begin n_fail++; $display("FAIL mid_word_count: got %0d expected 3", words.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < words.size()) begin
        n_chk++; if (words[k] !== exp3[k]) begin n_fail++; $display("FAIL mid_word%0d: got %h expected %h", k, words[k], exp3[k]); end
      end
    end
    @(negedge clk);
    words.delete();
    pulse(1'b1, 1'b0);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (wn !== WORD_CYC + LW) begin n_fail++; $display("FAIL mid_resend_latency: got %0d expected %0d", wn, WORD_CYC + LW); end
    n_chk++; if (words.size() !== 1) begin n_fail++; $display("FAIL mid_resend_count: got %0d expected 1", words.size()); end
    if (words.size() > 0) begin
      n_chk++; if (words[0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mid_resend_word: got %h expected a5a5a5a5", words[0]); end
    end
    @(negedge clk);
  endtask

  task automatic test_empty_and_busy();
    int bn, wn, lo, hi, rs, rl, d0; bit ok;
    wr(12, 32'hDEAD_BEEF);
    rs = sclk_rises; rl = le_falls; d0 = done_cnt;
    pulse(1'b1, 1'b0);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (wn !== 1) begin n_fail++; $display("FAIL empty_done_latency: got %0d expected 1", wn); end
    n_chk++; if (sclk_rises - rs !== 0) begin n_fail++; $display("FAIL empty_sclk: got %0d expected 0", sclk_rises - rs); end
    n_chk++; if (le_falls - rl !== 0) begin n_fail++; $display("FAIL empty_le: got %0d expected 0", le_falls - rl); end
    @(negedge clk);
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL empty_done_count: got %0d expected 1", done_cnt - d0); end
    wr(0, 32'h0BAD_F00D);
    words.delete();
    d0 = done_cnt;
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    pulse(1'b0, 1'b1);
    run_flush(bn, wn, lo, hi, ok);
    repeat (150) @(negedge clk);
    n_chk++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count: got %0d expected 1", done_cnt - d0); end
    n_chk++; if (words.size() !== 1) begin n_fail++; $display("FAIL busy_ignore_words: got %0d expected 1", words.size()); end
    if (words.size() > 0) begin
      n_chk++; if (words[0] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL busy_ignore_word: got %h expected 0badf00d", words[0]); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_word();
    int bn, wn, lo, hi, nz; bit ok;
    wr(9, 32'hFFFF_0000);
    words.delete();
    pulse(1'b1, 1'b0);
    repeat (66) @(negedge clk);
    n_chk++; if (nbits !== 16) begin n_fail++; $display("FAIL rst_bits_sent: got %0d expected 16", nbits); end
    n_chk++; if (le !== 1'b0) begin n_fail++; $display("FAIL rst_le_low_midword: got %b expected 0", le); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({ce, le, sclk, sdata, busy} !== 5'b01000) begin n_fail++; $display("FAIL rst_async_pins: got %b expected 01000", {ce, le, sclk, sdata, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (words.size() !== 0) begin n_fail++; $display("FAIL rst_partial_discard: got %0d expected 0", words.size()); end
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (bn !== 1320 + LW) begin n_fail++; $display("FAIL rst_all_dirty_busy: got %0d expected %0d", bn, 1320 + LW); end
    n_chk++; if (words.size() !== 10) begin n_fail++; $display("FAIL rst_all_dirty_count: got %0d expected 10", words.size()); end
    nz = 0;
    foreach (words[k]) if (words[k] !== 32'h0) nz++;
    n_chk++; if (nz !== 0) begin n_fail++; $display("FAIL rst_regs_zero: got %0d nonzero words expected 0", nz); end
    @(negedge clk);
  endtask

  task automatic test_lock_sync();
    muxout = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_low: got %b expected 0", lock); end
    muxout = 1'b1;
    @(negedge clk);
    n_chk++; if (lock !== 1'b0) begin n_fail++; $display("FAIL lock_delay1: got %b expected 0", lock); end
    @(negedge clk);
    n_chk++; if (lock !== 1'b1) begin n_fail++; $display("FAIL lock_delay2: got %b expected 1", lock); end
`ifndef PLL_LOCK_WAIT_EN
    n_chk++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lock_err_tied: got %b expected 0", lock_err); end
`endif
  endtask

`ifdef PLL_LOCK_WAIT_EN
  task automatic test_lock_wait();
    int bn, wn, lo, hi; bit ok;
    muxout = 1'b0;
    repeat (3) @(negedge clk);
    wr(0, 32'h0000_0001);
    pulse(1'b1, 1'b0);
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (wn !== WORD_CYC + 4096) begin n_fail++; $display("FAIL lockwait_timeout_latency: got %0d expected %0d", wn, WORD_CYC + 4096); end
    n_chk++; if (lock_err !== 1'b1) begin n_fail++; $display("FAIL lockwait_err_set: got %b expected 1", lock_err); end
    @(negedge clk);
    wr(0, 32'h0000_0002);
    pulse(1'b1, 1'b0);
    n_chk++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lockwait_err_cleared: got %b expected 0", lock_err); end
    repeat (231) @(negedge clk);
    muxout = 1'b1;
    run_flush(bn, wn, lo, hi, ok);
    n_chk++; if (!ok || wn !== 3) begin n_fail++; $display("FAIL lockwait_lock_latency: got %0d expected 3", wn); end
    n_chk++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL lockwait_err_clear: got %b expected 0", lock_err); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_all = 1'b0; muxout = (LW == 1);
    test_reset();
    test_full_flush();
    test_single_word();
    test_mid_flush_write();
    test_empty_and_busy();
    test_reset_mid_word();
    test_lock_sync();
`ifdef PLL_LOCK_WAIT_EN
    test_lock_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
